fp_acc_sat: RTL and testbench
=============================

# fp_acc_sat

Saturating fixed-point accumulator directly downstream of the fixed-point multiplier. It consumes N_TERMS signed Q(W_len-W_fract).W_fract products and their overflow/underflow flags. It sums them in a guard-bit-extended register and emits one saturated W_len-bit sum per group over a valid/ready handshake. This forms the accumulate half of a multiply-accumulate (dot-product) datapath.

## Interface
- W_len, 16, word length of products and result
- W_fract, 14, fractional bits (informational; the binary point is unchanged by addition)
- N_TERMS, 8, products summed per result (≥2)
- G_BITS, 4, accumulator guard bits; must satisfy 2^G_BITS ≥ N_TERMS
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  product/flags valid
- in_ready  out  1  block can accept a term
- product  in  W_len  signed term from multiplier
- in_ovf  in  1  multiplier overflow flag for this term
- in_unf  in  1  multiplier underflow flag for this term
- out_valid  out  1  sum valid
- out_ready  in  1  consumer accepts sum
- sum  out  W_len  signed saturated group sum
- sum_ovf  out  1  group sum clipped to max positive
- sum_unf  out  1  group sum clipped to min negative
- term_sat  out  1  at least one term in the group was substituted because of an input flag

## Operation
- There are two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset: state=ACC, acc=0, count=0, sum=0, sum_ovf=0, sum_unf=0, term_sat=0, out_valid=0.
- A term is accepted when in_valid&&in_ready.
- Term substitution:
  - in_ovf=1 → term = 2^(W_len-1)-1 (0x7FFF).
  - Otherwise in_unf=1 → term = -2^(W_len-1) (0x8000).
  - Otherwise term = product.
  - in_ovf has priority when both flags are set.
  - Substitution sets an internal sticky flag for the group.
- acc (W_len+G_BITS bits, signed) += sign-extended term. acc never wraps under the G_BITS rule.
- count increments per accepted term. When the accepted term is the N_TERMSth (count==N_TERMS-1):
  - acc is saturated to W_len and registered into sum.
  - acc > max → sum=max, sum_ovf=1.
  - acc < min → sum=min, sum_unf=1.
  - Otherwise sum=acc[W_len-1:0] with both flags 0.
  - term_sat ← sticky flag.
  - state → HOLD.
- HOLD: sum, sum_ovf, sum_unf and term_sat stay stable until out_valid&&out_ready. On that handshake:
  - acc=0, count=0, sticky=0, state → ACC.
  - sum and the flags keep their last value; they are only meaningful while out_valid=1.
- in_valid while in HOLD is ignored. The term is not consumed, and the upstream stage must hold it.

## Timing
- Result latency: out_valid rises the cycle after the last term is accepted.
- Throughput: at most one term per cycle in ACC. Best case is N_TERMS+1 cycles per result, because there is no same-cycle ACC re-entry bypass.
- in_ready and out_valid are pure state decodes with no combinational path from in_valid or out_ready.
- An asserted reset mid-group discards the partial sum immediately; accumulation restarts from count=0 after deassertion.

## Configuration
- FP_ACC_CLEAR_EN defined:
  - Adds input port `clear` (1 bit, synchronous).
  - clear=1 in any state forces acc=0, count=0, sticky=0, out_valid=0, state=ACC on the next edge.
  - clear beats a same-cycle term acceptance (the term is dropped) and a same-cycle output handshake (the result is discarded).
- Not defined: there is no `clear` port; groups end only by count or reset.

## Test plan
- Nominal group: W_len=16, W_fract=14, 8 terms of 0x0800 (0.125), all flags 0 → one cycle after the 8th accept, out_valid=1, sum=0x4000, sum_ovf=0, sum_unf=0, term_sat=0.
- Positive saturation: 8×0x1000 (0.25; true sum 2.0) → sum=0x7FFF, sum_ovf=1, sum_unf=0.
- Negative saturation: 8×0xC000 (-1.0; true sum -8.0) → sum=0x8000, sum_unf=1, sum_ovf=0.
- Flag substitution: term 1 = 0x0000 with in_ovf=1 and in_unf=1, terms 2–8 = 0x0000 → sum=0x7FFF, sum_ovf=0, term_sat=1.
- Backpressure: complete a group, hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, sum stable, no term consumed. Then pulse out_ready → in_ready=1 next cycle, and the next group accumulates from zero.
- Reset mid-group: accept 3 terms of 0x2000, assert reset → all outputs 0 during reset. Then 8×0x0400 → sum=0x2000 (no residue from the aborted group).

Source files
------------

// File: rtl/fp_acc_sat.sv
// Saturating fixed-point accumulator for a multiply-accumulate datapath.
// Sums N_TERMS signed products in a guard-bit-extended register, then emits
// one saturated W_len-bit result per group over a valid/ready handshake.
// Optional feature: define FP_ACC_CLEAR_EN to add a synchronous `clear` input
// that aborts the current group from any state.
module fp_acc_sat #(
    parameter int unsigned W_len   = 16,
    parameter int unsigned W_fract = 14,
    parameter int unsigned N_TERMS = 8,
    parameter int unsigned G_BITS  = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef FP_ACC_CLEAR_EN
    input  logic             clear,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_len-1:0] product,
    input  logic             in_ovf,
    input  logic             in_unf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_len-1:0] sum,
    output logic             sum_ovf,
    output logic             sum_unf,
    output logic             term_sat
);

    localparam int unsigned AW = W_len + G_BITS;
    localparam int unsigned CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    localparam logic [CW-1:0]        LastCount = CW'(N_TERMS - 1);
    localparam logic [W_len-1:0]     TermMax   = {1'b0, {(W_len-1){1'b1}}};
    localparam logic [W_len-1:0]     TermMin   = {1'b1, {(W_len-1){1'b0}}};
    localparam logic signed [AW-1:0] SatMax    = {{(G_BITS+1){1'b0}}, {(W_len-1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin    = {{(G_BITS+1){1'b1}}, {(W_len-1){1'b0}}};

    // Reject configurations where the accumulator could wrap or the format is empty.
    if (((1 << G_BITS) < N_TERMS) || (N_TERMS < 2) || (W_fract >= W_len)) begin : g_bad_cfg
        $error("fp_acc_sat: invalid parameter combination");
    end

    typedef enum logic [0:0] {StAcc, StHold} state_e;

    state_e                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  sticky_q, sticky_d;
    logic [W_len-1:0]      sum_q, sum_d;
    logic                  sum_ovf_q, sum_ovf_d;
    logic                  sum_unf_q, sum_unf_d;
    logic                  term_sat_q, term_sat_d;

    logic [W_len-1:0]      term;
    logic signed [AW-1:0]  acc_next;
    logic                  sticky_next;

    // Flag substitution (overflow wins) and the sign-extended running sum.
    always_comb begin
        if (in_ovf) begin
            term = TermMax;
        end else if (in_unf) begin
            term = TermMin;
        end else begin
            term = product;
        end
        acc_next    = acc_q + {{G_BITS{term[W_len-1]}}, term};
        sticky_next = sticky_q | in_ovf | in_unf;
    end

    // Next-state logic: accumulate in StAcc, present the result in StHold.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        sticky_d   = sticky_q;
        sum_d      = sum_q;
        sum_ovf_d  = sum_ovf_q;
        sum_unf_d  = sum_unf_q;
        term_sat_d = term_sat_q;

        unique case (state_q)
            StAcc: begin
                if (in_valid) begin
                    acc_d    = acc_next;
                    sticky_d = sticky_next;
                    if (count_q == LastCount) begin
                        if (acc_next > SatMax) begin
                            sum_d     = TermMax;
                            sum_ovf_d = 1'b1;
                            sum_unf_d = 1'b0;
                        end else if (acc_next < SatMin) begin
                            sum_d     = TermMin;
                            sum_ovf_d = 1'b0;
                            sum_unf_d = 1'b1;
                        end else begin
                            sum_d     = acc_next[W_len-1:0];
                            sum_ovf_d = 1'b0;
                            sum_unf_d = 1'b0;
                        end
                        term_sat_d = sticky_next;
                        state_d    = StHold;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    acc_d    = '0;
                    count_d  = '0;
                    sticky_d = 1'b0;
                    state_d  = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase

`ifdef FP_ACC_CLEAR_EN
        // Clear drops any same-cycle term and discards any pending result.
        if (clear) begin
            state_d    = StAcc;
            acc_d      = '0;
            count_d    = '0;
            sticky_d   = 1'b0;
            sum_d      = sum_q;
            sum_ovf_d  = sum_ovf_q;
            sum_unf_d  = sum_unf_q;
            term_sat_d = term_sat_q;
        end
`endif
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StAcc;
            acc_q      <= '0;
            count_q    <= '0;
            sticky_q   <= 1'b0;
            sum_q      <= '0;
            sum_ovf_q  <= 1'b0;
            sum_unf_q  <= 1'b0;
            term_sat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            sum_q      <= sum_d;
            sum_ovf_q  <= sum_ovf_d;
            sum_unf_q  <= sum_unf_d;
            term_sat_q <= term_sat_d;
        end
    end

    // Handshake signals are pure state decodes.
    always_comb begin
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StHold);
        sum       = sum_q;
        sum_ovf   = sum_ovf_q;
        sum_unf   = sum_unf_q;
        term_sat  = term_sat_q;
    end

endmodule

// File: tb/tb_fp_acc_sat.sv
// Scoreboard bench for fp_acc_sat: directed cases then randomized groups,
// checked against an integer reference model of the group sum.
module tb_fp_acc_sat;

    localparam int W = 16;
    localparam int N = 8;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  product;
    logic          in_ovf;
    logic          in_unf;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          sum_ovf;
    logic          sum_unf;
    logic          term_sat;

    fp_acc_sat #(
        .W_len   (16),
        .W_fract (14),
        .N_TERMS (8),
        .G_BITS  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef FP_ACC_CLEAR_EN
        .clear     (clear),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .in_ovf    (in_ovf),
        .in_unf    (in_unf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .sum_ovf   (sum_ovf),
        .sum_unf   (sum_unf),
        .term_sat  (term_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         ovf;
        logic         unf;
        logic         tsat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   results_pushed = 0;
    int   results_seen = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

    // Reference model state: plain integer sum of the current group.
    int   acc_m = 0;
    int   count_m = 0;
    logic sticky_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        acc_m    = 0;
        count_m  = 0;
        sticky_m = 1'b0;
    endtask

    function automatic bit model_accept(input logic [W-1:0] p, input logic o, input logic u);
        int   t;
        exp_t e;
        if (o)      t = 32767;
        else if (u) t = -32768;
        else        t = int'($signed(p));
        acc_m    += t;
        sticky_m |= (o | u);
        count_m++;
        if (count_m < N) return 1'b0;
        if (acc_m > 32767) begin
            e.sum = 16'h7FFF; e.ovf = 1'b1; e.unf = 1'b0;
        end else if (acc_m < -32768) begin
            e.sum = 16'h8000; e.ovf = 1'b0; e.unf = 1'b1;
        end else begin
            e.sum = 16'(acc_m); e.ovf = 1'b0; e.unf = 1'b0;
        end
        e.tsat = sticky_m;
        exp_q.push_back(e);
        results_pushed++;
        acc_m    = 0;
        count_m  = 0;
        sticky_m = 1'b0;
        return 1'b1;
    endfunction

    // Present one term, wait (bounded) until it is accepted, update the model.
    task automatic send_term(input logic [W-1:0] p, input logic o, input logic u);
        int waited = 0;
        bit done = 1'b0;
        @(negedge clk); #1;
        in_valid = 1'b1;
        product  = p;
        in_ovf   = o;
        in_unf   = u;
        #1;
        while (!in_ready && waited < 300) begin
            waited++;
            @(negedge clk); #2;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            done = model_accept(p, o, u);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (done) begin
            @(negedge clk); #2;
            chk("latency_out_valid", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk); #3;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] rnd_prod();
        int v;
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        v = int'($urandom_range(0, 8191)) - 4096;
        return 16'(v);
    endfunction

    // Consumer backpressure.
    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(negedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare on each output handshake, and check stability while held.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(sum), 32'hFFFF_FFFF);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    results_seen++;
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("sum_ovf", 32'(sum_ovf), 32'(e.ovf));
                    chk("sum_unf", 32'(sum_unf), 32'(e.unf));
                    chk("term_sat", 32'(term_sat), 32'(e.tsat));
                end else begin
                    e = exp_q[0];
                    chk("hold_sum_stable", 32'(sum), 32'(e.sum));
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        product  = '0;
        in_ovf   = 1'b0;
        in_unf   = 1'b0;
        rdy_mode = 0;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", {29'd0, sum_ovf, sum_unf, term_sat}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b1;

        // Nominal: 8 x 0.125 -> 1.0 (0x4000).
        for (int i = 0; i < N; i++) send_term(16'h0800, 1'b0, 1'b0);
        drain();
        // Positive saturation: 8 x 0.25.
        for (int i = 0; i < N; i++) send_term(16'h1000, 1'b0, 1'b0);
        drain();
        // Negative saturation: 8 x -1.0.
        for (int i = 0; i < N; i++) send_term(16'hC000, 1'b0, 1'b0);
        drain();
        // Both flags on the first term: overflow substitution wins.
        send_term(16'h0000, 1'b1, 1'b1);
        for (int i = 1; i < N; i++) send_term(16'h0000, 1'b0, 1'b0);
        drain();
        // Underflow substitution alone.
        send_term(16'h0100, 1'b0, 1'b1);
        for (int i = 1; i < N; i++) send_term(16'h0100, 1'b0, 1'b0);
        drain();

        // Backpressure: result held while a new term waits upstream.
        rdy_mode = 2;
        for (int i = 0; i < N; i++) send_term(16'h0100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            in_valid = 1'b1;
            product  = 16'h1234;
            in_ovf   = 1'b0;
            in_unf   = 1'b0;
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        rdy_mode = 0;
        @(negedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < N; i++) send_term(16'h0040, 1'b0, 1'b0);
        drain();

        // Reset mid-group discards the partial sum.
        for (int i = 0; i < 3; i++) send_term(16'h2000, 1'b0, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_flags", {29'd0, sum_ovf, sum_unf, term_sat}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) send_term(16'h0400, 1'b0, 1'b0);
        drain();

        // Randomized groups with random gaps, flags and backpressure.
        rdy_mode = 1;
        for (int g = 0; g < 40; g++) begin
            for (int i = 0; i < N; i++) begin
                logic o;
                logic u;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                o = ($urandom_range(0, 15) == 0);
                u = ($urandom_range(0, 15) == 0);
                send_term(rnd_prod(), o, u);
            end
        end
        rdy_mode = 0;
        drain();

        chk("results_count", 32'(results_seen), 32'(results_pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
